// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI slave receiver: mode encoding, frame state, sync depth floor.
// Pure declarations, no timing or flow control of its own.
package spi_pkg;

  localparam int MIN_SYNC_STAGES = 2;

  typedef enum logic [1:0] {
    MODE0 = 2'b00,
    MODE1 = 2'b01,
    MODE2 = 2'b10,
    MODE3 = 2'b11
  } spi_mode_t;

  typedef enum logic {
    IDLE   = 1'b0,
    ACTIVE = 1'b1
  } frame_state_t;

  function automatic spi_mode_t mode_of(input logic cpol, input logic cpha);
    return spi_mode_t'({cpol, cpha});
  endfunction

  function automatic logic idle_level(input spi_mode_t mode);
    return (mode == MODE2) || (mode == MODE3);
  endfunction

  // Leading edge is rising for CPOL=0; CPHA=1 moves sampling to the trailing edge.
  function automatic logic sample_on_rise(input spi_mode_t mode);
    return (mode == MODE0) || (mode == MODE3);
  endfunction

endpackage

// File: rtl/spi_slave_rx_if.sv
// Pin-side SPI signals plus the internal rx valid/ready and tx valid/ready buses.
// slave modport faces the receiver; master modport faces the SPI master and the consumer.
interface spi_slave_rx_if #(
  parameter int WIDTH = 8
);
  logic             spi_sck;
  logic             spi_mosi;
  logic             spi_ss_n;
  logic             spi_miso;
  logic [WIDTH-1:0] rx_data;
  logic             rx_valid;
  logic             rx_ready;
  logic             rx_overflow;
  logic             overflow_clear;
  logic [WIDTH-1:0] tx_data;
  logic             tx_valid;
  logic             tx_ready;
  logic             busy;

  modport slave (
    input  spi_sck, spi_mosi, spi_ss_n, rx_ready, overflow_clear, tx_data, tx_valid,
    output spi_miso, rx_data, rx_valid, rx_overflow, tx_ready, busy
  );

  modport master (
    output spi_sck, spi_mosi, spi_ss_n, rx_ready, overflow_clear, tx_data, tx_valid,
    input  spi_miso, rx_data, rx_valid, rx_overflow, tx_ready, busy
  );
endinterface

// File: rtl/sync_fifo.sv
// First-word-fall-through FIFO: a push is visible at o_head the next cycle.
// Push when full is dropped (flagged on o_drop) unless a pop frees the slot in the same cycle.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_push_dat,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty,
  output logic             o_drop
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wr;
  logic [AW:0]      r_rd;
  logic             w_do_pop;
  logic             w_do_push;

  // Extra pointer bit tells full from empty when the indices match.
  assign o_empty   = (r_wr == r_rd);
  assign o_full    = (r_wr[AW] != r_rd[AW]) && (r_wr[AW-1:0] == r_rd[AW-1:0]);
  assign w_do_pop  = i_pop && !o_empty;
  assign w_do_push = i_push && (!o_full || w_do_pop);
  assign o_drop    = i_push && !w_do_push;
  assign o_head    = r_mem[r_rd[AW-1:0]];

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_wr <= '0;
      r_rd <= '0;
      for (int i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (w_do_push) begin
        r_mem[r_wr[AW-1:0]] <= i_push_dat;
        r_wr                <= r_wr + (AW+1)'(1);
      end
      if (w_do_pop) begin
        r_rd <= r_rd + (AW+1)'(1);
      end
    end
  end

endmodule

// File: rtl/spi_slave_rx.sv
// Oversampled SPI slave: sync -> edge detect -> shift -> rx FIFO (word visible 1 cycle after last sample).
// rx backpressure via FIFO with sticky overflow; MISO path only when SPI_SLAVE_RX_TX_EN is defined.
module spi_slave_rx
  import spi_pkg::*;
#(
  parameter int WIDTH       = 8,
  parameter int FIFO_DEPTH  = 4,
  parameter int CPOL        = 0,
  parameter int CPHA        = 0,
  parameter int LSB_FIRST   = 1,
  parameter int SYNC_STAGES = 2
) (
  input logic           clock,
  input logic           reset,
  spi_slave_rx_if.slave bus
);
  localparam spi_mode_t MODE        = mode_of(1'(CPOL), 1'(CPHA));
  localparam logic      SCK_IDLE    = idle_level(MODE);
  localparam logic      SAMPLE_RISE = sample_on_rise(MODE);
  localparam int        SYNC_N      = (SYNC_STAGES < MIN_SYNC_STAGES) ? MIN_SYNC_STAGES : SYNC_STAGES;
  localparam int        CW          = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST_BIT = CW'(WIDTH - 1);

  logic [SYNC_N-1:0] r_sck_sync;
  logic [SYNC_N-1:0] r_mosi_sync;
  logic [SYNC_N-1:0] r_ss_sync;
  logic              r_sck_d;
  logic              r_ss_d;
  frame_state_t      r_state;
  logic [CW-1:0]     r_cnt;
  logic [WIDTH-1:0]  r_shift;
  logic              r_overflow;

  logic             w_sck;
  logic             w_ss;
  logic             w_mosi;
  logic             w_sck_rise;
  logic             w_sck_fall;
  logic             w_sample;
  logic             w_ss_fall;
  logic             w_ss_rise;
  logic [WIDTH-1:0] w_word;
  logic             w_push;
  logic             w_pop;
  logic [WIDTH-1:0] w_head;
  logic             w_full;
  logic             w_empty;
  logic             w_drop;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_sck_sync  <= {SYNC_N{SCK_IDLE}};
      r_mosi_sync <= '0;
      r_ss_sync   <= '1;
      r_sck_d     <= SCK_IDLE;
      r_ss_d      <= 1'b1;
    end else begin
      r_sck_sync  <= {r_sck_sync[SYNC_N-2:0], bus.spi_sck};
      r_mosi_sync <= {r_mosi_sync[SYNC_N-2:0], bus.spi_mosi};
      r_ss_sync   <= {r_ss_sync[SYNC_N-2:0], bus.spi_ss_n};
      r_sck_d     <= r_sck_sync[SYNC_N-1];
      r_ss_d      <= r_ss_sync[SYNC_N-1];
    end
  end

  assign w_sck      = r_sck_sync[SYNC_N-1];
  assign w_ss       = r_ss_sync[SYNC_N-1];
  assign w_mosi     = r_mosi_sync[SYNC_N-1];
  assign w_sck_rise = w_sck && !r_sck_d;
  assign w_sck_fall = !w_sck && r_sck_d;
  assign w_sample   = SAMPLE_RISE ? w_sck_rise : w_sck_fall;
  assign w_ss_fall  = !w_ss && r_ss_d;
  assign w_ss_rise  = w_ss && !r_ss_d;

  assign w_word = (LSB_FIRST != 0) ? {w_mosi, r_shift[WIDTH-1:1]}
                                   : {r_shift[WIDTH-2:0], w_mosi};

  // Word completes on the sample edge carrying its last bit; that same cycle writes the FIFO.
  assign w_push = (r_state == ACTIVE) && !w_ss_rise && w_sample && (r_cnt == LAST_BIT);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_shift <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_ss_fall) begin
            r_state <= ACTIVE;
            r_cnt   <= '0;
            r_shift <= '0;
          end
        end
        ACTIVE: begin
          if (w_ss_rise) begin
            r_state <= IDLE;
            r_cnt   <= '0;
          end else if (w_sample) begin
            r_shift <= w_word;
            r_cnt   <= (r_cnt == LAST_BIT) ? '0 : r_cnt + CW'(1);
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign w_pop = !w_empty && bus.rx_ready;

  sync_fifo #(
    .WIDTH (WIDTH),
    .DEPTH (FIFO_DEPTH)
  ) u_rx_fifo (
    .i_clk      (clock),
    .i_rst      (reset),
    .i_push     (w_push),
    .i_push_dat (w_word),
    .i_pop      (w_pop),
    .o_head     (w_head),
    .o_full     (w_full),
    .o_empty    (w_empty),
    .o_drop     (w_drop)
  );

  // A drop in the same cycle as a clear must leave the flag set.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_overflow <= 1'b0;
    end else if (w_drop) begin
      r_overflow <= 1'b1;
    end else if (bus.overflow_clear) begin
      r_overflow <= 1'b0;
    end
  end

  assign bus.rx_data     = w_head;
  assign bus.rx_valid    = !w_empty;
  assign bus.rx_overflow = r_overflow;
  assign bus.busy        = !w_ss;

`ifdef SPI_SLAVE_RX_TX_EN
  logic [WIDTH-1:0] r_hold;
  logic             r_hold_vld;
  logic [WIDTH-1:0] r_tx_shift;
  logic             r_miso;
  logic             w_tx_hs;
  logic             w_entry;
  logic             w_shift_edge;
  logic [WIDTH-1:0] w_tx_next;
  logic             w_next_first;
  logic             w_exit_bit;

  assign w_tx_hs      = bus.tx_valid && !r_hold_vld;
  assign w_entry      = (r_state == IDLE) && w_ss_fall;
  assign w_shift_edge = SAMPLE_RISE ? w_sck_fall : w_sck_rise;
  assign w_tx_next    = r_hold_vld ? r_hold : '0;
  assign w_next_first = (LSB_FIRST != 0) ? w_tx_next[0] : w_tx_next[WIDTH-1];
  assign w_exit_bit   = (LSB_FIRST != 0) ? r_tx_shift[0] : r_tx_shift[WIDTH-1];

  // Mid-frame loads do not touch MISO: the next shift-out edge presents the new first bit.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_hold     <= '0;
      r_hold_vld <= 1'b0;
      r_tx_shift <= '0;
      r_miso     <= 1'b0;
    end else begin
      if (w_tx_hs) begin
        r_hold     <= bus.tx_data;
        r_hold_vld <= 1'b1;
      end else if (w_entry || w_push) begin
        r_hold_vld <= 1'b0;
      end
      if (w_entry) begin
        if (CPHA == 0) begin
          r_miso     <= w_next_first;
          r_tx_shift <= (LSB_FIRST != 0) ? (w_tx_next >> 1) : (w_tx_next << 1);
        end else begin
          r_miso     <= 1'b0;
          r_tx_shift <= w_tx_next;
        end
      end else if ((r_state == ACTIVE) && w_ss_rise) begin
        r_miso <= 1'b0;
      end else if (w_push) begin
        r_tx_shift <= w_tx_next;
      end else if ((r_state == ACTIVE) && w_shift_edge) begin
        r_miso     <= w_exit_bit;
        r_tx_shift <= (LSB_FIRST != 0) ? (r_tx_shift >> 1) : (r_tx_shift << 1);
      end
    end
  end

  assign bus.spi_miso = r_miso;
  assign bus.tx_ready = !r_hold_vld;
`else
  logic w_unused_tx;

  assign w_unused_tx  = ^{bus.tx_data, bus.tx_valid, w_full};
  assign bus.spi_miso = 1'b0;
  assign bus.tx_ready = 1'b0;
`endif

endmodule

// File: tb/tb_spi_slave_rx.sv
// Directed bench: four receivers in different modes driven by a bit-banged SPI master.
// Expected words, FIFO order and flag values are hand-computed constants.
module tb_spi_slave_rx;
  localparam int HALF = 10;
`ifdef SPI_SLAVE_RX_TX_EN
  localparam logic TX_ON = 1'b1;
`else
  localparam logic TX_ON = 1'b0;
`endif

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  int         checks = 0;
  int         failures = 0;
  logic       sck_r  [4];
  logic       mosi_r [4];
  logic       ssn_r  [4];
  logic       rdy_r  [4];
  logic       clr_r  [4];
  logic [7:0] tx_dat0 = 8'h00;
  logic       tx_vld0 = 1'b0;

  always #5 clock = ~clock;

  spi_slave_rx_if #(.WIDTH(8))  if0 ();
  spi_slave_rx_if #(.WIDTH(12)) if1 ();
  spi_slave_rx_if #(.WIDTH(12)) if2 ();
  spi_slave_rx_if #(.WIDTH(12)) if3 ();

  assign if0.spi_sck = sck_r[0];  assign if0.spi_mosi = mosi_r[0]; assign if0.spi_ss_n = ssn_r[0];
  assign if1.spi_sck = sck_r[1];  assign if1.spi_mosi = mosi_r[1]; assign if1.spi_ss_n = ssn_r[1];
  assign if2.spi_sck = sck_r[2];  assign if2.spi_mosi = mosi_r[2]; assign if2.spi_ss_n = ssn_r[2];
  assign if3.spi_sck = sck_r[3];  assign if3.spi_mosi = mosi_r[3]; assign if3.spi_ss_n = ssn_r[3];
  assign if0.rx_ready = rdy_r[0]; assign if0.overflow_clear = clr_r[0];
  assign if1.rx_ready = rdy_r[1]; assign if1.overflow_clear = clr_r[1];
  assign if2.rx_ready = rdy_r[2]; assign if2.overflow_clear = clr_r[2];
  assign if3.rx_ready = rdy_r[3]; assign if3.overflow_clear = clr_r[3];
  assign if0.tx_data = tx_dat0;   assign if0.tx_valid = tx_vld0;
  assign if1.tx_data = '0;        assign if1.tx_valid = 1'b0;
  assign if2.tx_data = '0;        assign if2.tx_valid = 1'b0;
  assign if3.tx_data = '0;        assign if3.tx_valid = 1'b0;

  spi_slave_rx #(.WIDTH(8), .FIFO_DEPTH(4), .CPOL(0), .CPHA(0), .LSB_FIRST(1), .SYNC_STAGES(2))
    u0 (.clock(clock), .reset(reset), .bus(if0));
  spi_slave_rx #(.WIDTH(12), .FIFO_DEPTH(4), .CPOL(1), .CPHA(1), .LSB_FIRST(0), .SYNC_STAGES(2))
    u1 (.clock(clock), .reset(reset), .bus(if1));
  spi_slave_rx #(.WIDTH(12), .FIFO_DEPTH(4), .CPOL(0), .CPHA(1), .LSB_FIRST(0), .SYNC_STAGES(2))
    u2 (.clock(clock), .reset(reset), .bus(if2));
  spi_slave_rx #(.WIDTH(12), .FIFO_DEPTH(4), .CPOL(1), .CPHA(0), .LSB_FIRST(0), .SYNC_STAGES(2))
    u3 (.clock(clock), .reset(reset), .bus(if3));

  function automatic int w_of(input int d);
    return (d == 0) ? 8 : 12;
  endfunction
  function automatic logic cpol_of(input int d);
    return (d == 1) || (d == 3);
  endfunction
  function automatic logic cpha_of(input int d);
    return (d == 1) || (d == 2);
  endfunction
  function automatic logic lsb_of(input int d);
    return (d == 0);
  endfunction

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(negedge clock);
  endtask

  task automatic get_out(input int d, output logic [31:0] dat, output logic [31:0] vld,
                         output logic [31:0] ovf, output logic miso);
    case (d)
      0:       begin dat = 32'(if0.rx_data); vld = 32'(if0.rx_valid); ovf = 32'(if0.rx_overflow); miso = if0.spi_miso; end
      1:       begin dat = 32'(if1.rx_data); vld = 32'(if1.rx_valid); ovf = 32'(if1.rx_overflow); miso = if1.spi_miso; end
      2:       begin dat = 32'(if2.rx_data); vld = 32'(if2.rx_valid); ovf = 32'(if2.rx_overflow); miso = if2.spi_miso; end
      default: begin dat = 32'(if3.rx_data); vld = 32'(if3.rx_valid); ovf = 32'(if3.rx_overflow); miso = if3.spi_miso; end
    endcase
  endtask

  task automatic send_bit(input int d, input logic b, output logic m);
    logic [31:0] dat, vld, ovf;
    if (!cpha_of(d)) begin
      mosi_r[d] = b;
      tick(HALF);
      get_out(d, dat, vld, ovf, m);
      sck_r[d] = ~cpol_of(d);
      tick(HALF);
      sck_r[d] = cpol_of(d);
    end else begin
      sck_r[d]  = ~cpol_of(d);
      mosi_r[d] = b;
      tick(HALF);
      get_out(d, dat, vld, ovf, m);
      sck_r[d] = cpol_of(d);
      tick(HALF);
    end
  endtask

  task automatic send_word(input int d, input logic [31:0] data, input int nbits, output logic [31:0] cap);
    int   idx;
    logic m;
    cap = '0;
    for (int i = 0; i < nbits; i++) begin
      idx = lsb_of(d) ? i : (w_of(d) - 1 - i);
      send_bit(d, data[idx], m);
      cap[idx] = m;
    end
  endtask

  // Last bit on u0 with the rx_valid rise pinned to the cycle after the edge is detected.
  task automatic last_bit0(input logic b, input logic pop_at_push, output logic [31:0] v_pre,
                           output logic [31:0] v_post);
    mosi_r[0] = b;
    tick(HALF);
    sck_r[0] = 1'b1;
    tick(2);
    v_pre = 32'(if0.rx_valid);
    if (pop_at_push) rdy_r[0] = 1'b1;
    tick(1);
    rdy_r[0] = 1'b0;
    v_post = 32'(if0.rx_valid);
    tick(HALF - 3);
    sck_r[0] = 1'b0;
  endtask

  task automatic frame_begin(input int d);
    ssn_r[d] = 1'b0;
    tick(HALF);
  endtask

  task automatic frame_end(input int d);
    tick(HALF);
    ssn_r[d] = 1'b1;
    tick(HALF);
  endtask

  task automatic pop(input int d);
    rdy_r[d] = 1'b1;
    tick(1);
    rdy_r[d] = 1'b0;
  endtask

  task automatic expect_head(input int d, input string tag, input logic [31:0] exp);
    logic [31:0] dat, vld, ovf;
    logic        m;
    get_out(d, dat, vld, ovf, m);
    chk({tag, "_vld"}, vld, 32'd1);
    chk(tag, dat, exp);
    pop(d);
  endtask

  task automatic expect_empty(input int d, input string tag);
    logic [31:0] dat, vld, ovf;
    logic        m;
    get_out(d, dat, vld, ovf, m);
    chk(tag, vld, 32'd0);
  endtask

  initial begin
    logic [31:0] cap, v_pre, v_post, dat, vld, ovf;
    logic        m;
    logic [7:0]  w8;
    for (int d = 0; d < 4; d++) begin
      sck_r[d]  = cpol_of(d);
      mosi_r[d] = 1'b0;
      ssn_r[d]  = 1'b1;
      rdy_r[d]  = 1'b0;
      clr_r[d]  = 1'b0;
    end
    tick(3);
    chk("rst_vld",   32'(if0.rx_valid),    32'd0);
    chk("rst_data",  32'(if0.rx_data),     32'd0);
    chk("rst_ovf",   32'(if0.rx_overflow), 32'd0);
    chk("rst_miso",  32'(if0.spi_miso),    32'd0);
    chk("rst_txrdy", 32'(if0.tx_ready),    32'(TX_ON));
    chk("rst_busy",  32'(if0.busy),        32'd0);
    reset = 1'b0;
    tick(5);

    // Mode 0 LSB-first 0xA5 with exact rx_valid timing
    w8 = 8'hA5;
    frame_begin(0);
    chk("a_busy", 32'(if0.busy), 32'd1);
    send_word(0, 32'(w8), 7, cap);
    last_bit0(w8[7], 1'b0, v_pre, v_post);
    chk("a_vld_early", v_pre, 32'd0);
    chk("a_vld_d1", v_post, 32'd1);
    frame_end(0);
    chk("a_miso_cap", cap, 32'd0);
    chk("a_ovf", 32'(if0.rx_overflow), 32'd0);
    expect_head(0, "a_data", 32'hA5);
    expect_empty(0, "a_empty");

    // 12-bit MSB-first in modes 3, 1, 2
    frame_begin(1); send_word(1, 32'hABC, 12, cap); frame_end(1);
    expect_head(1, "m3_data", 32'hABC);
    frame_begin(2); send_word(2, 32'h5A5, 12, cap); frame_end(2);
    expect_head(2, "m1_data", 32'h5A5);
    frame_begin(3); send_word(3, 32'h5A5, 12, cap); frame_end(3);
    expect_head(3, "m2_data", 32'h5A5);

    // Partial word aborted by ss_n, then a full word
    frame_begin(0); send_word(0, 32'hFF, 5, cap); frame_end(0);
    expect_empty(0, "part_empty");
    frame_begin(0); send_word(0, 32'h3C, 8, cap); frame_end(0);
    expect_head(0, "part_data", 32'h3C);
    expect_empty(0, "part_only");

    // Overflow: five back-to-back words into a four-deep FIFO
    frame_begin(0);
    for (int k = 1; k <= 5; k++) send_word(0, 32'(k), 8, cap);
    frame_end(0);
    get_out(0, dat, vld, ovf, m);
    chk("ovf_set", ovf, 32'd1);
    clr_r[0] = 1'b1; tick(1); clr_r[0] = 1'b0;
    get_out(0, dat, vld, ovf, m);
    chk("ovf_clr", ovf, 32'd0);
    expect_head(0, "ovf_q0", 32'h01);
    expect_head(0, "ovf_q1", 32'h02);
    expect_head(0, "ovf_q2", 32'h03);
    expect_head(0, "ovf_q3", 32'h04);
    expect_empty(0, "ovf_empty");

    // Push and pop in the same cycle while full
    w8 = 8'h15;
    frame_begin(0);
    for (int k = 17; k <= 20; k++) send_word(0, 32'(k), 8, cap);
    send_word(0, 32'(w8), 7, cap);
    last_bit0(w8[7], 1'b1, v_pre, v_post);
    frame_end(0);
    get_out(0, dat, vld, ovf, m);
    chk("pp_ovf", ovf, 32'd0);
    expect_head(0, "pp_q0", 32'h12);
    expect_head(0, "pp_q1", 32'h13);
    expect_head(0, "pp_q2", 32'h14);
    expect_head(0, "pp_q3", 32'h15);
    expect_empty(0, "pp_empty");

    // Transmit: one loaded word, then an empty holding register
    tx_dat0 = 8'hC3; tx_vld0 = 1'b1;
    tick(1);
    tx_vld0 = 1'b0;
    tick(1);
    chk("tx_rdy_full", 32'(if0.tx_ready), 32'd0);
    frame_begin(0);
    chk("tx_rdy_load", 32'(if0.tx_ready), 32'(TX_ON));
    send_word(0, 32'h00, 8, cap);
    chk("tx_word0", cap, TX_ON ? 32'hC3 : 32'h00);
    send_word(0, 32'h00, 8, cap);
    chk("tx_word1", cap, 32'h00);
    frame_end(0);
    chk("tx_miso_idle", 32'(if0.spi_miso), 32'd0);
    expect_head(0, "tx_rx0", 32'h00);
    expect_head(0, "tx_rx1", 32'h00);

    // Reset in the middle of a word
    frame_begin(0);
    send_word(0, 32'hFF, 4, cap);
    reset = 1'b1;
    tick(1);
    chk("mid_rst_busy", 32'(if0.busy), 32'd0);
    tick(2);
    reset = 1'b0;
    ssn_r[0] = 1'b1;
    sck_r[0] = 1'b0;
    tick(HALF);
    expect_empty(0, "mid_rst_empty");
    frame_begin(0); send_word(0, 32'h81, 8, cap); frame_end(0);
    expect_head(0, "mid_rst_data", 32'h81);
    expect_empty(0, "mid_rst_spur");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #1000000;
    failures++;
    $display("FAIL watchdog got=timeout exp=finish");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_slave_rx.md
Name: spi_slave_rx

Overview:
Parametrised SPI slave port for the k12a peripheral set. It generalises the 8-bit, mode-0, LSB-first capture logic used on the spi0 bench into a synthesisable block. Supported variations: word width, all four CPOL/CPHA modes, bit order, a slave-select framed bit counter, a receive FIFO with overflow detection, and an optional MISO transmit path. It sits between the SPI pins and an internal valid/ready bus. All SPI inputs are oversampled in the system clock domain.

Parameters:
WIDTH, 8, bits per SPI word (2..32)
FIFO_DEPTH, 4, receive FIFO entries (power of two, >=2)
CPOL, 0, SCK idle level
CPHA, 0, 0 = sample on leading edge, 1 = sample on trailing edge
LSB_FIRST, 1, 1 = first bit on the wire is bit 0
SYNC_STAGES, 2, synchroniser flops on sck/mosi/ss_n (>=2)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous active-high reset
spi_sck  input  1  SPI clock from master
spi_mosi  input  1  master-out data
spi_ss_n  input  1  active-low slave select
spi_miso  output  1  slave-out data
rx_data  output  WIDTH  head of receive FIFO
rx_valid  output  1  FIFO non-empty
rx_ready  input  1  consumer pops head when rx_valid && rx_ready
rx_overflow  output  1  sticky: a word was dropped
overflow_clear  input  1  clears rx_overflow
tx_data  input  WIDTH  next word to transmit
tx_valid  input  1  tx_data offered
tx_ready  output  1  holding register empty
busy  output  1  synchronised ss_n low

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset values: rx_valid=0, rx_data=0, rx_overflow=0, spi_miso=0, tx_ready=1, busy=0. Synchroniser contents are set to idle: sck=CPOL, ss_n=1. The bit counter and shift register are cleared.
- Synchronisation: sck, mosi and ss_n each pass through SYNC_STAGES flops. Edges are detected by comparing each synchronised signal with a one-cycle-delayed copy.
- Sample edge: the leading edge when CPHA=0, the trailing edge when CPHA=1. Leading means rising if CPOL=0 and falling if CPOL=1. Shift-out edge is the opposite edge.
- Master constraint: SCK half-period must be >= SYNC_STAGES+2 clocks. Behaviour below that is undefined.
- Framing, states IDLE and ACTIVE:
  - IDLE->ACTIVE on the synchronised ss_n falling edge. This clears the bit counter and loads the TX shifter.
  - ACTIVE->IDLE on the synchronised ss_n rising edge. Any partial word (counter != 0) is discarded and no FIFO write occurs.
  - SCK edges in IDLE are ignored.
- Receive:
  - On each sample edge in ACTIVE, mosi shifts in. With LSB_FIRST it enters at the MSB and shifts right; otherwise it enters at the LSB and shifts left. The counter increments modulo WIDTH.
  - At the sample edge with counter==WIDTH-1, the assembled word (including the current bit) is written to the FIFO in that same cycle D.
  - rx_valid rises in cycle D+1 (first-word-fall-through).
  - Counter wraps to 0 and framing continues without ss_n deassertion.
- FIFO:
  - A push when full drops the new word and sets rx_overflow. Existing contents are unchanged.
  - Push and pop in the same cycle when full: both succeed, occupancy unchanged, no overflow.
  - Pop when empty: no effect.
  - overflow_clear in the same cycle as a new overflow: the set wins.
- Transmit (feature enabled):
  - A tx_valid&&tx_ready handshake fills the holding register; tx_ready falls the next cycle.
  - At ACTIVE entry and at each word completion, the holding register moves to the TX shifter and tx_ready rises. If the holding register is empty, all-zeros are loaded.
  - CPHA=0: the first bit drives spi_miso from load. Subsequent bits change on the shift-out edge.
  - CPHA=1: every bit, including the first, changes on the shift-out edge.
  - Bit order follows LSB_FIRST. spi_miso=0 in IDLE.
- Reset mid-transfer: all state returns to reset values immediately. The block stays IDLE until the next synchronised ss_n falling edge.

Optional Feature:
- Macro SPI_SLAVE_RX_TX_EN.
- Defined: the transmit path above is present.
- Undefined: spi_miso is tied 0, tx_ready is tied 0, and tx_data/tx_valid are ignored. No holding register or TX shifter is synthesised.

Decomposition:
- Package spi_pkg holds:
  - spi_mode_t enum (MODE0..MODE3), with helpers deriving the sample-edge and idle levels;
  - frame state enum (IDLE, ACTIVE);
  - localparam for minimum SYNC_STAGES.
- One sub-module, sync_fifo (parameters WIDTH, DEPTH; push/pop/full/empty), holds the receive FIFO. Synchroniser, framing and shifters stay in spi_slave_rx.

Test Plan:
- Mode 0, LSB_FIRST=1, ss_n low, master sends 0xA5 at sck period 20 clocks -> rx_data=0xA5, rx_valid=1 one cycle after the 8th rising edge is detected. rx_overflow=0.
- WIDTH=12, CPOL=1, CPHA=1, LSB_FIRST=0, send 0xABC -> rx_data=0xABC. Repeat for modes 1 and 2 with 0x5A5 -> correct capture.
- ss_n raised after 5 bits of 0xFF, then full word 0x3C -> FIFO holds only 0x3C.
- rx_ready=0, send FIFO_DEPTH+1 words 0x01..0x05 -> FIFO holds 0x01..0x04 and rx_overflow=1. overflow_clear -> 0. Pop while pushing at full -> no overflow.
- TX enabled, tx_data=0xC3 loaded before ss_n falls, master sends 0x00 -> spi_miso bit sequence captured by master =0xC3. With no second load, the next word returns 0x00.
- Assert reset after 4 bits of a word, release, send 0x81 -> rx_data=0x81 with no stale bits and no spurious FIFO entry.
